// File: rtl/mips_mem_pkg.sv
// Shared types for the store read-modify-write block.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mips_mem_pkg;

    localparam int MEM_DATA_W = 32;

    // The encoding matches the raw 2-bit size input, so the input can be cast directly.
    typedef enum logic [1:0] {
        WORD    = 2'b00,
        HALF    = 2'b01,
        BYTE_HI = 2'b10,
        BYTE_LO = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/store_lane_merge.sv
// Merges new store data into an old memory word according to store size.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs.
//
// Ports:
//   size   - store width (WORD, HALF, BYTE_HI, BYTE_LO)
//   old    - word previously read from memory
//   wdata  - source register value; only its low byte/halfword is used for sub-word stores
//   merged - word to be written back
module store_lane_merge
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] old,
    input  logic [31:0] wdata,
    output logic [31:0] merged
);

    always_comb begin
        merged = wdata;
        case (size_t'(size))
            WORD:    merged = wdata;
            HALF:    merged = {old[31:16], wdata[15:0]};
            // The high lane takes the low byte of the source, not wdata[31:24].
            BYTE_HI: merged = {wdata[7:0], old[23:0]};
            BYTE_LO: merged = {old[31:8], wdata[7:0]};
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/store_merge_rmw.sv
// Store unit: word stores write directly; sub-word stores read, merge and write back.
// Latency: done arrives 2 cycles after the start edge for words, 4 for sub-words.
// Backpressure: none queued; start is ignored while busy.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   start, size,
//   addr, wdata       - request; sampled only in IDLE
//   mem_rdata         - read data, valid the cycle after a read address
//   mem_addr, mem_wdata,
//   mem_wr            - memory interface; mem_wr pulses once per store
//   busy, done        - status; done is a one-cycle completion pulse
module store_merge_rmw
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic [1:0]        size_q;
    logic              accept;
    logic              capture;
    logic [DATA_W-1:0] merged;

    // Single clocked process: state plus every operand register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            size_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                size_q  <= size;
            end
            if (capture) begin
                old_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        mem_wr  = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept  = 1'b1;
                    state_d = (size_t'(size) == WORD) ? WRITE : READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                capture = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                mem_wr  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The latched address is presented in every state. It is zero after reset,
    // and it is the correct address during both READ and WRITE.
    assign mem_addr = addr_q;

    // Driven continuously from registers, so it is never X; it matters only in WRITE.
    // For word stores old_q is stale, but the merge ignores it.
    store_lane_merge u_merge (
        .size   (size_q),
        .old    (old_q),
        .wdata  (wdata_q),
        .merged (merged)
    );

    assign mem_wdata = merged;

endmodule

// File: tb/tb_store_merge_rmw.sv
module tb_store_merge_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    store_merge_rmw #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .busy      (busy),
        .done      (done)
    );

    // Memory model: synchronous read with one-cycle latency, and write on mem_wr.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[5:2]];
        if (mem_wr) mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT issues must match the next expected write, in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wr === 1'b1) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", mem_addr, mem_wdata);
                end else begin
                    check("write_addr", mem_addr, exp_addr_q.pop_front());
                    check("write_data", mem_wdata, exp_data_q.pop_front());
                end
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Waits from inside cycle 1 after the sampling edge until done, then returns its cycle index.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_d, input int exp_lat);
        int lat;
        expect_write(a, exp_d);
        @(negedge clk);
        start = 1'b1; size = sz; addr = a; wdata = wd;
        @(negedge clk);
        // Scramble inputs after the sampling edge; the operands are already latched.
        start = 1'b0; size = ~sz; addr = 32'hFFFF_FFF0; wdata = 32'h0BAD_0BAD;
        wait_done(lat);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1122_3344;
        reset = 1'b1; start = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        // Directed vectors; expected words are computed by hand from the merge rules.
        run_op("word",   2'b00, 32'h40, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2);
        run_op("half",   2'b01, 32'h44, 32'hAAAA_BBBB, 32'h1122_BBBB, 4);
        run_op("bytehi", 2'b10, 32'h48, 32'h0000_00CC, 32'hCC22_3344, 4);
        run_op("bytelo", 2'b11, 32'h4C, 32'h0000_00CC, 32'h1122_33CC, 4);
        run_op("half2",  2'b01, 32'h40, 32'h5555_1234, 32'hDEAD_1234, 4);
        run_op("bytehi2",2'b10, 32'h44, 32'h1234_5677, 32'h7722_BBBB, 4);

        // Reset asserted in WAIT aborts the request: no write and no done.
        @(negedge clk);
        start = 1'b1; size = 2'b01; addr = 32'h50; wdata = 32'h0000_EEEE;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_done_cnt", done_cnt, 6);

        // Reset takes priority over start in the same cycle.
        reset = 1'b1; start = 1'b1; size = 2'b00; addr = 32'h5C; wdata = 32'h1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // start while busy with a different address is ignored.
        expect_write(32'h54, 32'h1122_ABCD);
        @(negedge clk);
        start = 1'b1; size = 2'b01; addr = 32'h54; wdata = 32'h0000_ABCD;
        @(negedge clk);
        addr = 32'h58; wdata = 32'hFFFF_FFFF; size = 2'b00;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("busy_ign_latency", lat, 3);
        repeat (6) @(negedge clk);
        check("busy_ign_done_cnt", done_cnt, 7);

        // Back-to-back: start held high across DONE -> IDLE.
        expect_write(32'h58, 32'hCAFE_F00D);
        expect_write(32'h50, 32'h1122_3399);
        @(negedge clk);
        start = 1'b1; size = 2'b00; addr = 32'h58; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        wait_done(lat);
        check("b2b_first_latency", lat, 2);
        size = 2'b11; addr = 32'h50; wdata = 32'h0000_0099;
        @(negedge clk);
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("b2b_second_latency", lat, 4);
        repeat (4) @(negedge clk);

        check("final_done_cnt", done_cnt, 9);
        check("pending_writes", exp_addr_q.size(), 0);
        check("mem_0x50", mem[4'd4], 32'h1122_3399);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_merge_rmw.md
STORE_MERGE_RMW -- requirements
Module: store_merge_rmw

Interface
REQ-001 Parameter: DATA_W, default 32, memory data and address width; only 32 is supported.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 size  input  2  store width: 00 word, 01 halfword [15:0], 10 byte lane [31:24], 11 byte lane [7:0].
REQ-006 addr  input  32  word-aligned target address.
REQ-007 wdata  input  32  source register value; only low byte/halfword used for sub-word stores.
REQ-008 mem_rdata  input  32  memory read data, valid the cycle after an address is presented with mem_wr=0.
REQ-009 mem_addr  output  32  memory address.
REQ-010 mem_wdata  output  32  merged write word.
REQ-011 mem_wr  output  1  memory write strobe, one cycle per store.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, READ, WAIT, WRITE, DONE.
REQ-015 In IDLE with start=1, the block SHALL register addr, wdata and size; next state WRITE if size=00, else READ.
REQ-016 READ SHALL drive mem_addr=latched addr with mem_wr=0 for one cycle, then go to WAIT.
REQ-017 WAIT SHALL capture mem_rdata into an internal word register at the end of the cycle, then go to WRITE.
REQ-018 WRITE SHALL assert mem_wr=1 for exactly one cycle with mem_addr=latched addr and mem_wdata=merged word, then go to DONE.
REQ-019 Merge rules: 00 -> wdata; 01 -> {old[31:16], wdata[15:0]}; 10 -> {wdata[7:0], old[23:0]}; 11 -> {old[31:8], wdata[7:0]}.
REQ-020 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-021 Latency from the start-sampling edge to the done cycle SHALL be 2 cycles for word stores and 4 cycles for sub-word stores.
REQ-022 start SHALL be ignored when busy=1; no queuing.
REQ-023 Inputs SHALL NOT affect an operation after the start-sampling edge, since all operands are latched.
REQ-024 Outside WRITE, mem_wr SHALL be 0; mem_wdata is don't-care but SHALL be driven (no X).
REQ-025 A start accepted in the same cycle the block returns to IDLE from DONE SHALL begin a new operation on that edge.

Reset
REQ-026 reset SHALL force state IDLE and set mem_wr=0, done=0, busy=0, mem_addr=0, mem_wdata=0, and all latched registers to 0.
REQ-027 reset asserted in any state, including WAIT or WRITE, SHALL abort the operation: no write is issued after the reset edge and no done pulse is produced.
REQ-028 reset SHALL take priority over start in the same cycle.

Structure
REQ-029 Package mips_mem_pkg SHALL hold the size_t enum (WORD, HALF, BYTE_HI, BYTE_LO, with values per REQ-005) and the state_t enum.
REQ-030 The merge function SHALL live in one combinational sub-module, store_lane_merge (inputs size, old, wdata; output merged word), instantiated once.
REQ-031 State register and operand registers SHALL be in a single clocked process; next-state and outputs SHALL be combinational from state.

Verification
REQ-032 Word store: size=00, addr=0x40, wdata=0xDEADBEEF -> no READ cycle; mem_wr=1 one cycle with mem_addr=0x40, mem_wdata=0xDEADBEEF; done 2 cycles after start.
REQ-033 Halfword store: memory word 0x11223344, wdata=0xAAAABBBB, size=01 -> one read at addr, then write 0x1122BBBB; done 4 cycles after start.
REQ-034 Byte stores on memory word 0x11223344 with wdata=0x000000CC: size=10 -> writes 0xCC223344; size=11 -> writes 0x112233CC.
REQ-035 Reset mid-operation: assert reset in WAIT -> next cycle IDLE, busy=0; mem_wr never asserted and done never pulses for that request.
REQ-036 start pulsed while busy, with a different addr -> ignored; exactly one write occurs, to the original address.
REQ-037 Back-to-back: start held high across the DONE->IDLE transition -> second operation begins immediately, and both writes are correct.
